// File: rtl/spi_slave_burst.sv
// SPI slave for all CPOL/CPHA modes with multi-word bursts, fully synchronous to clk.
// Define SPI_SLAVE_LSB_FIRST_EN to shift words LSB first; MSB first otherwise.
module spi_slave_burst #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              spi_cs_n,
   input  logic              spi_sclk,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              tx_underrun,
   output logic              frame_abort,
   output logic              busy
);

   localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, LOAD, XFER, DONE} state_t;

   state_t              state_q, state_d;
   logic [SYNC_STAGES-1:0] cs_sync, mosi_sync;
   logic [SYNC_STAGES:0]   sclk_sync;
   logic                cs_s, mosi_s, sclk_s, sclk_prev;
   logic                sclk_edge, is_lead, sample_edge, shift_edge;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]   rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
   logic [DATA_W-1:0]   hold_q, hold_d, rx_data_d;
   logic [DATA_W-1:0]   rx_shift_in, tx_shift_nx;
   logic                cpol_q, cpol_d, cpha_q, cpha_d, first_q, first_d;
   logic                tx_ready_d, rx_valid_d, underrun_d, abort_d;
   logic                word_load, miso_nx;

   // Pin synchronisers; SCLK carries one extra stage so edges come from the last two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_sync   <= '1;
         sclk_sync <= '0;
         mosi_sync <= '0;
      end else begin
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         sclk_sync <= {sclk_sync[SYNC_STAGES-1:0], spi_sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      end
   end

   assign cs_s        = cs_sync[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync[SYNC_STAGES-1];
   assign sclk_s      = sclk_sync[SYNC_STAGES-1];
   assign sclk_prev   = sclk_sync[SYNC_STAGES];
   assign sclk_edge   = sclk_s ^ sclk_prev;
   assign is_lead     = sclk_s ^ cpol_q;
   assign sample_edge = sclk_edge & (is_lead ^ cpha_q);
   assign shift_edge  = sclk_edge & ~(is_lead ^ cpha_q);

`ifdef SPI_SLAVE_LSB_FIRST_EN
   assign rx_shift_in = {mosi_s, rx_shift_q[DATA_W-1:1]};
   assign tx_shift_nx = {1'b0, tx_shift_q[DATA_W-1:1]};
   assign miso_nx     = tx_shift_d[0];
`else
   assign rx_shift_in = {rx_shift_q[DATA_W-2:0], mosi_s};
   assign tx_shift_nx = {tx_shift_q[DATA_W-2:0], 1'b0};
   assign miso_nx     = tx_shift_d[DATA_W-1];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         hold_q      <= '0;
         cpol_q      <= 1'b0;
         cpha_q      <= 1'b0;
         first_q     <= 1'b0;
         spi_miso    <= 1'b0;
         spi_miso_oe <= 1'b0;
         tx_ready    <= 1'b1;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         frame_abort <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         hold_q      <= hold_d;
         cpol_q      <= cpol_d;
         cpha_q      <= cpha_d;
         first_q     <= first_d;
         spi_miso    <= (state_d != IDLE) ? miso_nx : 1'b0;
         spi_miso_oe <= (state_d != IDLE);
         tx_ready    <= tx_ready_d;
         rx_data     <= rx_data_d;
         rx_valid    <= rx_valid_d;
         tx_underrun <= underrun_d;
         frame_abort <= abort_d;
         busy        <= (state_d != IDLE);
      end
   end

   // Next-state, shift datapath and holding-register control
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      rx_shift_d = rx_shift_q;
      tx_shift_d = tx_shift_q;
      hold_d     = hold_q;
      cpol_d     = cpol_q;
      cpha_d     = cpha_q;
      first_d    = first_q;
      tx_ready_d = tx_ready;
      rx_data_d  = rx_data;
      rx_valid_d = 1'b0;
      underrun_d = 1'b0;
      abort_d    = 1'b0;
      word_load  = 1'b0;

      case (state_q)
         IDLE: begin
            if (en && !cs_s) state_d = LOAD;
         end
         LOAD: begin
            cpol_d    = cpol;
            cpha_d    = cpha;
            bit_cnt_d = '0;
            first_d   = !cpha;
            word_load = !cpha && en && !cs_s;
            state_d   = XFER;
         end
         XFER: begin
            if (sample_edge) begin
               rx_shift_d = rx_shift_in;
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  state_d   = DONE;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end else if (shift_edge) begin
               first_d = 1'b0;
               if (bit_cnt_q == '0 && !first_q) word_load  = 1'b1;
               else                              tx_shift_d = tx_shift_nx;
            end
         end
         DONE: begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            state_d    = XFER;
         end
         default: state_d = IDLE;
      endcase

      // Consume takes the old holding content before a same-cycle refill
      if (word_load) begin
         if (!tx_ready) begin
            tx_shift_d = hold_q;
            tx_ready_d = 1'b1;
         end else begin
            tx_shift_d = '0;
            underrun_d = 1'b1;
         end
      end
      if (tx_valid && tx_ready) begin
         hold_d     = tx_data;
         tx_ready_d = 1'b0;
      end

      // Frame end is evaluated after any same-cycle sample
      if (state_q != IDLE) begin
         if (!en || (cs_s && bit_cnt_d != '0)) begin
            abort_d = 1'b1;
            state_d = IDLE;
         end else if (cs_s) begin
            state_d = IDLE;
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_burst.sv
// Directed bench for spi_slave_burst: 8-bit and 16-bit instances driven by a bit-banged SPI master.
module tb_spi_slave_burst;

   localparam int H = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, m_cpol, m_cpha, sclk, mosi, sel16;
   logic en8, cs8, miso8, oe8, tx_valid8, tx_ready8, rx_valid8, und8, abort8, busy8;
   logic [7:0] tx_data8, rx_data8;
   logic en16, cs16, miso16, oe16, tx_valid16, tx_ready16, rx_valid16, und16, abort16, busy16;
   logic [15:0] tx_data16, rx_data16;

   int checks = 0;
   int failures = 0;
   int rx_cnt8 = 0, und_cnt8 = 0, abort_cnt8 = 0, rx_cnt16 = 0;
   logic [7:0]  q8[$];
   logic [15:0] q16[$];
   logic [7:0]  exp8;
   logic [15:0] exp16;

   spi_slave_burst u8 (
      .clk(clk), .rst(rst), .en(en8), .cpol(m_cpol), .cpha(m_cpha),
      .spi_cs_n(cs8), .spi_sclk(sclk), .spi_mosi(mosi),
      .spi_miso(miso8), .spi_miso_oe(oe8),
      .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
      .rx_data(rx_data8), .rx_valid(rx_valid8), .tx_underrun(und8),
      .frame_abort(abort8), .busy(busy8)
   );

   spi_slave_burst #(.DATA_W(16)) u16 (
      .clk(clk), .rst(rst), .en(en16), .cpol(m_cpol), .cpha(m_cpha),
      .spi_cs_n(cs16), .spi_sclk(sclk), .spi_mosi(mosi),
      .spi_miso(miso16), .spi_miso_oe(oe16),
      .tx_data(tx_data16), .tx_valid(tx_valid16), .tx_ready(tx_ready16),
      .rx_data(rx_data16), .rx_valid(rx_valid16), .tx_underrun(und16),
      .frame_abort(abort16), .busy(busy16)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: received words are popped against the queue of sent words
   always @(negedge clk) begin
      if (rx_valid8) begin
         rx_cnt8 = rx_cnt8 + 1;
         checks++;
         assert (q8.size() != 0) else begin
            failures++;
            $error("FAIL rx8_unexpected observed=0x%0h expected=none", rx_data8);
         end
         if (q8.size() != 0) begin
            exp8 = q8.pop_front();
            check("rx8_word", 32'(rx_data8), 32'(exp8));
         end
      end
      if (rx_valid16) begin
         rx_cnt16 = rx_cnt16 + 1;
         checks++;
         assert (q16.size() != 0) else begin
            failures++;
            $error("FAIL rx16_unexpected observed=0x%0h expected=none", rx_data16);
         end
         if (q16.size() != 0) begin
            exp16 = q16.pop_front();
            check("rx16_word", 32'(rx_data16), 32'(exp16));
         end
      end
      if (und8)   und_cnt8   = und_cnt8 + 1;
      if (abort8) abort_cnt8 = abort_cnt8 + 1;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic cur_miso();
      return sel16 ? miso16 : miso8;
   endfunction

   task automatic push_tx(input logic is16, input logic [15:0] d);
      int k = 0;
      while (!(is16 ? tx_ready16 : tx_ready8) && k < 50) begin
         wait_cycles(1);
         k++;
      end
      check("tx_ready_wait", 32'(k < 50), 32'd1);
      if (is16) begin
         tx_data16  = d;
         tx_valid16 = 1'b1;
      end else begin
         tx_data8  = d[7:0];
         tx_valid8 = 1'b1;
      end
      wait_cycles(1);
      tx_valid8  = 1'b0;
      tx_valid16 = 1'b0;
   endtask

   task automatic frame_begin(input logic is16, input logic pol, input logic pha);
      sel16  = is16;
      m_cpol = pol;
      m_cpha = pha;
      sclk   = pol;
      mosi   = 1'b0;
      wait_cycles(H);
      if (is16) cs16 = 1'b0; else cs8 = 1'b0;
      wait_cycles(H);
   endtask

   task automatic frame_end();
      wait_cycles(H);
      cs8  = 1'b1;
      cs16 = 1'b1;
      wait_cycles(2 * H);
   endtask

   // Master shifts n bits of tx (MSB first from bit w-1) and returns what it read on MISO
   task automatic spi_bits(input int w, input int n, input logic [15:0] tx, output logic [15:0] rx);
      rx = '0;
      for (int i = w - 1; i >= w - n; i--) begin
         if (!m_cpha) begin
            mosi = tx[i];
            wait_cycles(H);
            rx   = {rx[14:0], cur_miso()};
            sclk = ~m_cpol;
            wait_cycles(H);
            sclk = m_cpol;
         end else begin
            sclk = ~m_cpol;
            mosi = tx[i];
            wait_cycles(H);
            rx   = {rx[14:0], cur_miso()};
            sclk = m_cpol;
            wait_cycles(H);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] r;
      int base_rx, base_und, base_abort, k;

      rst = 1'b1;
      m_cpol = 1'b0; m_cpha = 1'b0; sclk = 1'b0; mosi = 1'b0; sel16 = 1'b0;
      en8 = 1'b0; cs8 = 1'b1; tx_valid8 = 1'b0; tx_data8 = '0;
      en16 = 1'b0; cs16 = 1'b1; tx_valid16 = 1'b0; tx_data16 = '0;
      wait_cycles(3);

      check("rst_miso",      32'(miso8),     32'd0);
      check("rst_miso_oe",   32'(oe8),       32'd0);
      check("rst_tx_ready",  32'(tx_ready8), 32'd1);
      check("rst_rx_data",   32'(rx_data8),  32'd0);
      check("rst_rx_valid",  32'(rx_valid8), 32'd0);
      check("rst_underrun",  32'(und8),      32'd0);
      check("rst_abort",     32'(abort8),    32'd0);
      check("rst_busy",      32'(busy8),     32'd0);

      rst = 1'b0;
      wait_cycles(2);
      en8 = 1'b1;
      wait_cycles(2);

      // Mode 0 single word
      push_tx(1'b0, 16'h3C);
      check("m0_tx_ready_full", 32'(tx_ready8), 32'd0);
      q8.push_back(8'hA5);
      base_rx = rx_cnt8;
      frame_begin(1'b0, 1'b0, 1'b0);
      check("m0_busy", 32'(busy8), 32'd1);
      check("m0_oe",   32'(oe8),   32'd1);
      spi_bits(8, 8, 16'h00A5, r);
      frame_end();
      check("m0_master_rx",   32'(r[7:0]),            32'h3C);
      check("m0_rx_pulses",   32'(rx_cnt8 - base_rx), 32'd1);
      check("m0_rx_data",     32'(rx_data8),          32'hA5);
      check("m0_tx_ready",    32'(tx_ready8),         32'd1);
      check("m0_busy_end",    32'(busy8),             32'd0);

      // Mode 3 burst of three words
      base_rx  = rx_cnt8;
      base_und = und_cnt8;
      push_tx(1'b0, 16'hC1);
      q8.push_back(8'h11); q8.push_back(8'h22); q8.push_back(8'h33);
      frame_begin(1'b0, 1'b1, 1'b1);
      spi_bits(8, 8, 16'h0011, r);
      check("m3_master_w0", 32'(r[7:0]), 32'hC1);
      push_tx(1'b0, 16'hC2);
      spi_bits(8, 8, 16'h0022, r);
      check("m3_master_w1", 32'(r[7:0]), 32'hC2);
      push_tx(1'b0, 16'hC3);
      spi_bits(8, 8, 16'h0033, r);
      check("m3_master_w2", 32'(r[7:0]), 32'hC3);
      frame_end();
      check("m3_rx_pulses", 32'(rx_cnt8 - base_rx),   32'd3);
      check("m3_underruns", 32'(und_cnt8 - base_und), 32'd0);

      // Modes 1 and 2
      push_tx(1'b0, 16'h96);
      q8.push_back(8'h5A);
      frame_begin(1'b0, 1'b0, 1'b1);
      spi_bits(8, 8, 16'h005A, r);
      frame_end();
      check("m1_master_rx", 32'(r[7:0]),   32'h96);
      check("m1_rx_data",   32'(rx_data8), 32'h5A);

      push_tx(1'b0, 16'h96);
      q8.push_back(8'h5A);
      frame_begin(1'b0, 1'b1, 1'b0);
      spi_bits(8, 8, 16'h005A, r);
      frame_end();
      check("m2_master_rx", 32'(r[7:0]),   32'h96);
      check("m2_rx_data",   32'(rx_data8), 32'h5A);

      // Empty holding register at frame start
      check("und_pre_empty", 32'(tx_ready8), 32'd1);
      base_und = und_cnt8;
      q8.push_back(8'h77);
      frame_begin(1'b0, 1'b0, 1'b0);
      check("und_in_load", 32'(und_cnt8 - base_und), 32'd1);
      spi_bits(8, 8, 16'h0077, r);
      frame_end();
      check("und_master_rx", 32'(r[7:0]), 32'h00);

      // CS raised after 5 bits
      base_rx    = rx_cnt8;
      base_abort = abort_cnt8;
      frame_begin(1'b0, 1'b0, 1'b0);
      spi_bits(8, 5, 16'h00E7, r);
      wait_cycles(H);
      cs8 = 1'b1;
      k = 0;
      while (busy8 && k < 20) begin
         wait_cycles(1);
         k++;
      end
      check("abort_busy_latency", 32'(k <= 4), 32'd1);
      wait_cycles(H);
      check("abort_pulses",  32'(abort_cnt8 - base_abort), 32'd1);
      check("abort_no_rx",   32'(rx_cnt8 - base_rx),       32'd0);
      check("abort_rx_data", 32'(rx_data8),                32'h77);

      // 16-bit instance, then reset mid-word
      en8  = 1'b0;
      en16 = 1'b1;
      push_tx(1'b1, 16'h1234);
      q16.push_back(16'hBEEF);
      frame_begin(1'b1, 1'b0, 1'b0);
      spi_bits(16, 16, 16'hBEEF, r);
      frame_end();
      check("w16_master_rx", 32'(r),          32'h1234);
      check("w16_rx_data",   32'(rx_data16),  32'hBEEF);
      check("w16_rx_pulses", 32'(rx_cnt16),   32'd1);

      frame_begin(1'b1, 1'b0, 1'b0);
      spi_bits(16, 6, 16'h0F0F, r);
      check("w16_busy_pre_rst", 32'(busy16), 32'd1);
      rst = 1'b1;
      #1;
      check("w16_rst_miso",     32'(miso16),     32'd0);
      check("w16_rst_oe",       32'(oe16),       32'd0);
      check("w16_rst_tx_ready", 32'(tx_ready16), 32'd1);
      check("w16_rst_rx_data",  32'(rx_data16),  32'd0);
      check("w16_rst_rx_valid", 32'(rx_valid16), 32'd0);
      check("w16_rst_underrun", 32'(und16),      32'd0);
      check("w16_rst_abort",    32'(abort16),    32'd0);
      check("w16_rst_busy",     32'(busy16),     32'd0);
      wait_cycles(2);
      cs16 = 1'b1;
      sclk = 1'b0;
      rst  = 1'b0;
      wait_cycles(H);

      push_tx(1'b1, 16'h4321);
      q16.push_back(16'hCAFE);
      frame_begin(1'b1, 1'b0, 1'b0);
      spi_bits(16, 16, 16'hCAFE, r);
      frame_end();
      check("w16_post_master_rx", 32'(r),         32'h4321);
      check("w16_post_rx_data",   32'(rx_data16), 32'hCAFE);

      check("sb8_drained",  32'(q8.size()),  32'd0);
      check("sb16_drained", 32'(q16.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_slave_burst.md
# spi_slave_burst

Parametrised SPI slave for all four CPOL/CPHA modes with configurable word width and multi-word bursts under one chip-select assertion. Pins are resynchronised into the system clock domain and SCLK edges are detected there, so the block is fully synchronous to `clk`. A one-word TX holding register with a valid/ready handshake feeds MISO, and each completed MOSI word is presented as a single-cycle `rx_valid` pulse. It sits between the board SPI pins and register-file or FIFO logic in the low-speed interface group.

## Interface
- `DATA_W`, default 8: bits per word, minimum 4.
- `SYNC_STAGES`, default 2: synchroniser depth on `spi_sclk`, `spi_cs_n` and `spi_mosi`, minimum 2.
- `clk`, input, 1: system clock. This is the only clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `en`, input, 1: block enable.
- `cpol`, input, 1: SCLK idle level. Captured at frame start.
- `cpha`, input, 1: clock phase (0 = sample on the leading edge). Captured at frame start.
- `spi_cs_n`, input, 1: chip select, active low.
- `spi_sclk`, input, 1: SPI clock.
- `spi_mosi`, input, 1: SPI data from the master.
- `spi_miso`, output, 1: SPI data to the master.
- `spi_miso_oe`, output, 1: MISO tristate enable.
- `tx_data`, input, DATA_W: next word to transmit.
- `tx_valid`, input, 1: `tx_data` is valid.
- `tx_ready`, output, 1: TX holding register is empty.
- `rx_data`, output, DATA_W: last complete received word.
- `rx_valid`, output, 1: one-cycle pulse when `rx_data` updates.
- `tx_underrun`, output, 1: one-cycle pulse when a word load found the holding register empty.
- `frame_abort`, output, 1: one-cycle pulse when CS rose mid-word or `en` fell mid-frame.
- `busy`, output, 1: a frame is in progress.

## Operation
- **Synchronisers:** reset values are `spi_cs_n` = 1, `spi_sclk` = 0, `spi_mosi` = 0. SCLK edges are detected from the last two synchronised stages.
- **Edge roles:** leading edge = transition away from the `cpol` idle level. Sample edge = leading edge if `cpha` = 0, trailing edge if `cpha` = 1. Shift edge = the other edge.
- **States:**
  - IDLE: leave when `en` = 1 and synchronised CS is low; go to LOAD.
  - LOAD: exactly one cycle. Latch `cpol`/`cpha`, clear `bit_cnt`. If `cpha` = 0, perform a word load. Go to XFER.
  - XFER: on a sample edge, shift MOSI into `rx_shift` (MSB first) and increment `bit_cnt`. When `bit_cnt` reaches DATA_W, wrap it to 0 and go to DONE.
  - DONE: exactly one cycle. `rx_data` <= `rx_shift`, pulse `rx_valid`, return to XFER (burst continues).
- **Word load:** if the holding register is full, `tx_shift` <= holding register and the holding register empties. Otherwise `tx_shift` <= 0 and `tx_underrun` pulses.
- **Shift edges in XFER:**
  - When `bit_cnt` = 0 and it is not the first shift edge of a `cpha` = 0 frame: word load.
  - Otherwise: shift `tx_shift` left, filling with 0.
  - The first shift edge of a `cpha` = 0 frame (the trailing edge of bit 0) is an ordinary shift.
- **MISO:** `spi_miso` = `tx_shift[DATA_W-1]` while `spi_miso_oe` = 1, else 0. `spi_miso_oe` = 1 in LOAD, XFER and DONE.
- **Holding register:** `tx_ready` = empty. `tx_valid` && `tx_ready` loads the register. A load request and a consume in the same cycle are both honoured; the consume takes the old content first.
- **Frame end:**
  - CS rises with `bit_cnt` = 0: return to IDLE quietly.
  - CS rises with `bit_cnt` != 0: pulse `frame_abort`, discard the partial word (no `rx_valid`), return to IDLE.
  - `en` = 0 in LOAD, XFER or DONE: treated as an abort.
  - The holding register is preserved across aborts.
- **No backpressure on RX:** the consumer must accept `rx_valid` when it pulses.
- **`busy`:** 1 in LOAD, XFER and DONE.

## Timing
- Reset values: `spi_miso` 0, `spi_miso_oe` 0, `tx_ready` 1, `rx_data` 0, `rx_valid` 0, `tx_underrun` 0, `frame_abort` 0, `busy` 0. State is IDLE.
- Pin-to-detect latency: SYNC_STAGES + 1 `clk` cycles.
- `rx_valid` asserts 2 cycles after detection of the last sample edge (XFER update, then DONE).
- MISO updates 1 cycle after shift-edge detection.
- SCLK constraint: each SCLK half-period must be at least SYNC_STAGES + 4 `clk` cycles, i.e. `clk` ≥ 12× SCLK at the default depth.
- CS-low to first SCLK edge: at least SYNC_STAGES + 3 `clk` cycles.
- A sample edge and a CS rise detected in the same cycle: the sample is taken first, then the CS-rise rules apply.

## Configuration
- `SPI_SLAVE_LSB_FIRST_EN`:
  - Defined: both shift registers run LSB first. `spi_miso` = `tx_shift[0]`, shifting right, and MOSI enters at `rx_shift[DATA_W-1]`.
  - Undefined (default): MSB first, as described above.

## Test plan
- Mode 0, DATA_W = 8, holding register = 0x3C, master sends 0xA5: `rx_data` = 0xA5 with one `rx_valid` pulse, master receives 0x3C, `tx_ready` returns to 1.
- Mode 3, burst of 0x11/0x22/0x33 with TX words 0xC1/0xC2/0xC3 supplied on `tx_ready`: three `rx_valid` pulses in order, master reads 0xC1/0xC2/0xC3, no `tx_underrun`.
- Modes 1 and 2, one word each with holding register = 0x96, master sends 0x5A: `rx_data` = 0x5A, master reads 0x96. The first MISO bit is valid on the first trailing edge.
- Holding register empty at frame start (mode 0): `tx_underrun` pulses once in LOAD and master reads 0x00.
- CS raised after 5 bits: `frame_abort` pulses, no `rx_valid`, `rx_data` unchanged, `busy` = 0 within SYNC_STAGES + 2 cycles.
- DATA_W = 16, mode 0, master sends 0xBEEF: `rx_data` = 0xBEEF. `rst` asserted mid-word: all outputs return to reset values immediately, and the next frame completes correctly.
